// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter: grants one master, holds through bursts, tracks data-phase owner.
// Latency: request sampled on an hready=1 edge -> registered grant one cycle later.
// Backpressure: hready=0 freezes grant, data-phase tracking and the round-robin pointer.
module ahb_slave_arbiter #(
    parameter int MASTER_NUM   = 4,
    parameter int MASTER_IDX_W = $clog2(MASTER_NUM)
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [MASTER_NUM-1:0]     hreq,
    input  logic [2*MASTER_NUM-1:0]   hmaster_htrans,
    input  logic                      hready,
    output logic [MASTER_NUM-1:0]     hgrant,
    output logic [MASTER_IDX_W-1:0]   hmaster_sel,
    output logic [MASTER_IDX_W-1:0]   hmaster_data,
    output logic                      data_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [MASTER_IDX_W:0]   NUM_EXT  = (MASTER_IDX_W+1)'(MASTER_NUM);
    localparam logic [MASTER_IDX_W-1:0] LAST_RST = MASTER_IDX_W'(MASTER_NUM - 1);

    state_t                    state, state_nxt;
    logic [MASTER_IDX_W-1:0]   last, last_nxt;
    logic [MASTER_NUM-1:0]     hgrant_nxt;
    logic [MASTER_IDX_W-1:0]   sel_nxt;
    logic [MASTER_IDX_W-1:0]   data_nxt;
    logic                      data_valid_nxt;

    logic [1:0]                owner_trans;
    logic                      owner_req;
    logic                      any_req;
    logic                      win_found;
    logic [MASTER_IDX_W-1:0]   win_idx;
    logic [MASTER_IDX_W:0]     cand;
    logic                      burst_hold;
    logic                      owner_xfer;

    // Owner's transfer type and request, selected without a variable part-select.
    always_comb begin
        owner_trans = 2'b00;
        owner_req   = 1'b0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (hmaster_sel == MASTER_IDX_W'(i)) begin
                owner_trans = hmaster_htrans[2*i +: 2];
                owner_req   = hreq[i];
            end
        end
    end

    assign any_req    = |hreq;
    assign burst_hold = ((owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY)) && owner_req;
    assign owner_xfer = (owner_trans == HTRANS_NONSEQ) || (owner_trans == HTRANS_SEQ);

    // Round-robin search starting at last+1; the wrap is explicit so MASTER_NUM need not be 2^n.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            cand = {1'b0, last} + (MASTER_IDX_W+1)'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!win_found && hreq[cand[MASTER_IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[MASTER_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        hgrant_nxt     = hgrant;
        sel_nxt        = hmaster_sel;
        data_nxt       = hmaster_data;
        data_valid_nxt = data_valid;

        if (hready) begin
            // Data phase captures the pre-update owner, so handover is bubble-free.
            if ((state == ST_OWNED) && owner_xfer) begin
                data_valid_nxt = 1'b1;
                data_nxt       = hmaster_sel;
            end else begin
                data_valid_nxt = 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (any_req && win_found) begin
                        state_nxt  = ST_OWNED;
                        sel_nxt    = win_idx;
                        last_nxt   = win_idx;
                        hgrant_nxt = MASTER_NUM'(1) << win_idx;
                    end
                end
                ST_OWNED: begin
                    if (burst_hold) begin
                        state_nxt = ST_OWNED;
                    end else if (any_req && win_found) begin
                        sel_nxt    = win_idx;
                        last_nxt   = win_idx;
                        hgrant_nxt = MASTER_NUM'(1) << win_idx;
                    end else begin
                        state_nxt  = ST_IDLE;
                        hgrant_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    hgrant_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state        <= ST_IDLE;
            last         <= LAST_RST;
            hgrant       <= '0;
            hmaster_sel  <= '0;
            hmaster_data <= '0;
            data_valid   <= 1'b0;
        end else begin
            state        <= state_nxt;
            last         <= last_nxt;
            hgrant       <= hgrant_nxt;
            hmaster_sel  <= sel_nxt;
            hmaster_data <= data_nxt;
            data_valid   <= data_valid_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter (4 masters): reset, rotation, burst hold, stalls, idle return.
module tb_ahb_slave_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    logic             hclk = 1'b0;
    logic             hreset_n = 1'b1;
    logic [N-1:0]     hreq = '0;
    logic [2*N-1:0]   hmaster_htrans = '0;
    logic             hready = 1'b1;
    logic [N-1:0]     hgrant;
    logic [W-1:0]     hmaster_sel;
    logic [W-1:0]     hmaster_data;
    logic             data_valid;

    int n_cmp = 0;
    int n_err = 0;

    ahb_slave_arbiter #(.MASTER_NUM(N)) dut (
        .hclk           (hclk),
        .hreset_n       (hreset_n),
        .hreq           (hreq),
        .hmaster_htrans (hmaster_htrans),
        .hready         (hready),
        .hgrant         (hgrant),
        .hmaster_sel    (hmaster_sel),
        .hmaster_data   (hmaster_data),
        .data_valid     (data_valid)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_tr(input int m, input logic [1:0] t);
        hmaster_htrans[2*m +: 2] = t;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int g, input int s, input int d, input int v);
        chk({tag, ".grant"}, hgrant, g);
        chk({tag, ".sel"}, hmaster_sel, s);
        chk({tag, ".data"}, hmaster_data, d);
        chk({tag, ".dv"}, data_valid, v);
    endtask

    task automatic pulse_reset(input string tag);
        #3 hreset_n = 1'b0;
        #1 chk_all(tag, 0, 0, 0, 0);
        #2 hreset_n = 1'b1;
    endtask

    // Burst-hold table: master 1 beats, with master 2 requesting throughout.
    logic [1:0] b_tr   [6] = '{TR_NONSEQ, TR_SEQ, TR_BUSY, TR_SEQ, TR_SEQ, TR_IDLE};
    logic [3:0] b_req  [6] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
    int         b_gnt  [6] = '{2, 2, 2, 2, 2, 4};
    int         b_dv   [6] = '{0, 1, 0, 1, 1, 0};
    int         b_dat  [6] = '{3, 1, 1, 1, 1, 1};
    int         rr_sel [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset state
        #1 hreset_n = 1'b0;
        #1 chk_all("rst", 0, 0, 0, 0);
        #5 hreset_n = 1'b1;

        // First grant after reset, then an asynchronous reset mid-cycle
        hreq = 4'b0001;
        set_tr(0, TR_NONSEQ);
        step();
        chk_all("first", 1, 0, 0, 0);
        step();
        chk_all("first2", 1, 0, 0, 1);
        pulse_reset("rst_mid");

        // Round-robin with every master requesting
        hreq = 4'b1111;
        for (int m = 0; m < N; m++) set_tr(m, TR_NONSEQ);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr%0d.sel", i), hmaster_sel, rr_sel[i]);
            chk($sformatf("rr%0d.grant", i), hgrant, 1 << rr_sel[i]);
            chk($sformatf("rr%0d.dv", i), data_valid, (i > 0) ? 1 : 0);
            if (i > 0) chk($sformatf("rr%0d.data", i), hmaster_data, rr_sel[i-1]);
        end

        // Burst hold for master 1 against master 2
        set_tr(0, TR_IDLE);
        set_tr(3, TR_IDLE);
        set_tr(2, TR_NONSEQ);
        for (int i = 0; i < 6; i++) begin
            hreq = b_req[i];
            set_tr(1, b_tr[i]);
            step();
            chk($sformatf("burst%0d.grant", i), hgrant, b_gnt[i]);
            chk($sformatf("burst%0d.dv", i), data_valid, b_dv[i]);
            chk($sformatf("burst%0d.data", i), hmaster_data, b_dat[i]);
        end

        // Wait states: owner 3 frozen while master 0 requests
        hreq = 4'b1000;
        set_tr(2, TR_IDLE);
        set_tr(3, TR_NONSEQ);
        step();
        chk_all("own3", 8, 3, 1, 0);
        hready = 1'b0;
        hreq = 4'b1001;
        set_tr(0, TR_NONSEQ);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("stall%0d", i), 8, 3, 1, 0);
        end
        hready = 1'b1;
        step();
        chk_all("handover", 1, 0, 3, 1);

        // Idle return: single NONSEQ from master 2
        hreq = 4'b0100;
        set_tr(0, TR_IDLE);
        set_tr(3, TR_IDLE);
        set_tr(2, TR_NONSEQ);
        step();
        chk_all("idle_g", 4, 2, 3, 0);
        hreq = 4'b0000;
        step();
        chk_all("idle_drop", 0, 2, 2, 1);
        set_tr(2, TR_IDLE);
        step();
        chk_all("idle_end", 0, 2, 2, 0);

        // Reset mid-burst: master 0 in beat 3 of a burst
        hreq = 4'b0001;
        set_tr(0, TR_NONSEQ);
        step();
        chk_all("mb_g", 1, 0, 2, 0);
        set_tr(0, TR_SEQ);
        step();
        chk_all("mb_b2", 1, 0, 0, 1);
        step();
        chk_all("mb_b3", 1, 0, 0, 1);
        pulse_reset("rst_burst");
        hreq = 4'b0011;
        set_tr(0, TR_NONSEQ);
        set_tr(1, TR_NONSEQ);
        step();
        chk_all("post_rst", 1, 0, 0, 0);
        step();
        chk_all("post_rst2", 2, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave arbiter of the AHB interconnect, one instance per slave port. It collects the request bit for its slave from every master-side address decoder, each decoder driving one `hreq` bit. It grants the slave to exactly one master using round-robin, and holds the grant for the length of a burst. It also tracks which master owns the data phase, so the downstream read-data and response muxes route correctly.

## Interface
Parameters:
- MASTER_NUM, 4: number of masters that can address this slave (≥2).
- MASTER_IDX_W, $clog2(MASTER_NUM): width of master index outputs.

Ports:
- hclk  input  1  interconnect clock; all state updates on rising edge.
- hreset_n  input  1  reset, asynchronous, active-low.
- hreq  input  MASTER_NUM  bit i = master i's decoder requests this slave; already gated to 0 when master i's htrans is IDLE.
- hmaster_htrans  input  2*MASTER_NUM  packed htrans_type per master; bits [2i+1:2i] = master i. Encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hready  input  1  slave hreadyout; 1 = current data phase completes this cycle.
- hgrant  output  MASTER_NUM  one-hot (or zero) address-phase grant, registered.
- hmaster_sel  output  MASTER_IDX_W  index of the granted master; drives the address/control mux into the slave.
- hmaster_data  output  MASTER_IDX_W  index of the master owning the current data phase; drives the hrdata/hresp return mux.
- data_valid  output  1  1 = a transfer from hmaster_data is in its data phase.

## Operation
- State machine with two states:
  - IDLE: no grant; hgrant=0.
  - OWNED: exactly one hgrant bit set, equal to 1<<hmaster_sel.
- Round-robin pointer `last` holds the index of the most recently granted master. Search order is last+1, last+2, … wrapping modulo MASTER_NUM; the first set hreq bit wins.
- Arbitration happens only in cycles with hready=1. With hready=0, hgrant, hmaster_sel, hmaster_data, data_valid and `last` all hold.
- IDLE, hready=1: any hreq set → pick winner, OWNED, last=winner. No hreq → stay IDLE.
- OWNED, hready=1, owner's htrans SEQ or BUSY and hreq[owner]=1 → keep grant; the burst is never broken.
- OWNED, hready=1, otherwise → re-arbitrate among all hreq bits, owner included.
  - Search starts after owner, so a repeating owner wins only if nobody else requests.
  - No requests → IDLE, hgrant=0.
- Data-phase tracking, on hready=1:
  - If in OWNED and owner's htrans is NONSEQ or SEQ: data_valid ← 1, hmaster_data ← hmaster_sel (the index before any update in this cycle).
  - Otherwise data_valid ← 0; hmaster_data holds.
- BUSY from the owner produces no data phase.
- Width rules:
  - Pointer increment wraps at MASTER_NUM, which need not be a power of two.
  - Index values ≥ MASTER_NUM never appear on outputs.

## Timing
- Reset (async assert, sync-safe deassert): hgrant=0, hmaster_sel=0, hmaster_data=0, data_valid=0, state IDLE, last=MASTER_NUM-1, so master 0 wins the first contention.
- Reset mid-burst: all outputs clear immediately, independent of hclk; no grant survives.
- Grant latency: hreq seen at edge N with hready=1 → hgrant valid after edge N (one cycle); combinational winner only feeds registers.
- Handover: a grant change and a data-phase owner update occur on the same edge. The old owner's final address phase becomes the data phase while the new owner starts its address phase (pipelined, no bubble).
- Stall: hready=0 for k cycles delays every update by exactly k cycles.
- Simultaneous events: requests from all masters in one cycle → one winner, chosen by the pointer; the losers keep requesting and are served in rotation.
- Owner drops hreq mid-burst while hready=1: treated as burst end; re-arbitrate.

## Test plan
- Reset check: assert hreset_n=0 mid-cycle → hgrant=0, hmaster_sel=0, hmaster_data=0, data_valid=0 immediately; after release, hreq=4'b0001, htrans0=NONSEQ, hready=1 → next cycle hgrant=0001, hmaster_sel=0.
- Round-robin: hreq=4'b1111, htrans all NONSEQ, hready=1 for 5 cycles → hmaster_sel sequence 0,1,2,3,0. hmaster_data lags hmaster_sel by one cycle; data_valid=1 from the second cycle.
- Burst hold: master 1 issues NONSEQ,SEQ,BUSY,SEQ,SEQ while master 2 requests throughout → hgrant=0010 for all 5 beats, then hgrant=0100. No data phase is recorded for the BUSY beat.
- Wait states: owner 3 granted, hready=0 for 3 cycles while master 0 requests → all outputs frozen for 3 cycles; handover to master 0 on the first hready=1 edge.
- Idle return: single NONSEQ from master 2, then hreq=0 → hgrant=0 one cycle after the NONSEQ is accepted; the next cycle data_valid=1 with hmaster_data=2, then data_valid=0.
- Reset mid-burst: master 0 in SEQ beat 3 of 8, assert reset → immediate clear. After release, last=MASTER_NUM-1, so master 0 wins over master 1 when both request.
